// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with redirect/hold priority and a small fully-associative BTB predictor.
module pc_gen #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               BTB_ENTRIES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_flag_i,
    input  logic             jump_flag_i,
    input  logic [WIDTH-1:0] jump_addr_i,
    input  logic             upd_valid_i,
    input  logic [WIDTH-1:0] upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [WIDTH-1:0] upd_target_i,
    output logic [WIDTH-1:0] inst_addr_o,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o
);
    localparam int IW = $clog2(BTB_ENTRIES);

    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]       tag_q [BTB_ENTRIES];
    logic [WIDTH-1:0]       tag_d [BTB_ENTRIES];
    logic [WIDTH-1:0]       tgt_q [BTB_ENTRIES];
    logic [WIDTH-1:0]       tgt_d [BTB_ENTRIES];
    logic [1:0]             cnt_q [BTB_ENTRIES];
    logic [1:0]             cnt_d [BTB_ENTRIES];
    logic [IW-1:0]          vic_q, vic_d;
    logic                   upd_hit;
    logic [IW-1:0]          upd_idx;

    // Tags are unique, so OR-ing over entries yields the single hit
    always_comb begin
        pred_taken_o  = 1'b0;
        pred_target_o = '0;
        upd_hit       = 1'b0;
        upd_idx       = '0;
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == pc_q && cnt_q[i][1]) begin
                pred_taken_o  = 1'b1;
                pred_target_o = tgt_q[i];
            end
            if (valid_q[i] && tag_q[i] == upd_pc_i) begin
                upd_hit = 1'b1;
                upd_idx = IW'(i);
            end
        end
    end

    assign pc_d = jump_flag_i  ? jump_addr_i :
                  hold_flag_i  ? pc_q :
                  pred_taken_o ? pred_target_o : pc_q + WIDTH'(4);
    assign inst_addr_o = pc_q;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        vic_d   = vic_q;
        if (upd_valid_i && upd_hit) begin
            if (upd_taken_i) begin
                cnt_d[upd_idx] = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'b01;
                tgt_d[upd_idx] = upd_target_i;
            end else begin
                cnt_d[upd_idx] = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'b01;
            end
        end else if (upd_valid_i && upd_taken_i) begin
            valid_d[vic_q] = 1'b1;
            tag_d[vic_q]   = upd_pc_i;
            tgt_d[vic_q]   = upd_target_i;
            cnt_d[vic_q]   = 2'b10;
            vic_d          = vic_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
            vic_q   <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            vic_q   <= vic_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scenario tasks plus random traffic checked against a FIFO-eviction BTB model.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, jump, uv, ut;
    logic [31:0] jaddr, upc, utgt;
    logic [31:0] inst_addr_o, pred_target_o;
    logic        pred_taken_o;
    int          checks = 0;
    int          passes = 0;

    bit [31:0] m_pc;
    bit [1:0]  m_cnt [bit [31:0]];
    bit [31:0] m_tgt [bit [31:0]];
    bit [31:0] m_q [$];

    pc_gen #(.WIDTH(32), .RESET_PC(32'h0), .BTB_ENTRIES(4)) dut (
        .clk(clk), .rst_n(rst_n), .hold_flag_i(hold), .jump_flag_i(jump), .jump_addr_i(jaddr),
        .upd_valid_i(uv), .upd_pc_i(upc), .upd_taken_i(ut), .upd_target_i(utgt),
        .inst_addr_o(inst_addr_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
    );

    always #5 clk = ~clk;

    function automatic bit mp(input bit [31:0] a);
        bit [1:0] c;
        if (!m_cnt.exists(a)) return 1'b0;
        c = m_cnt[a];
        return c[1];
    endfunction

    function automatic bit [31:0] mt(input bit [31:0] a);
        return mp(a) ? m_tgt[a] : 32'h0;
    endfunction

    task automatic idle();
        hold = 0; jump = 0; jaddr = 0; uv = 0; upc = 0; ut = 0; utgt = 0;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_cnt.delete();
        m_tgt.delete();
        m_q.delete();
    endtask

    // Advance one clock with the currently driven inputs; model sees pre-update state for prediction
    task automatic step();
        bit [31:0] nxt, v;
        bit [1:0]  c;
        nxt = jump ? jaddr : hold ? m_pc : mp(m_pc) ? m_tgt[m_pc] : m_pc + 32'd4;
        if (uv) begin
            if (m_cnt.exists(upc)) begin
                c = m_cnt[upc];
                if (ut) begin
                    m_cnt[upc] = (c == 2'd3) ? 2'd3 : c + 2'd1;
                    m_tgt[upc] = utgt;
                end else m_cnt[upc] = (c == 2'd0) ? 2'd0 : c - 2'd1;
            end else if (ut) begin
                if (m_q.size() == 4) begin
                    v = m_q.pop_front();
                    m_cnt.delete(v);
                    m_tgt.delete(v);
                end
                m_q.push_back(upc);
                m_cnt[upc] = 2'd2;
                m_tgt[upc] = utgt;
            end
        end
        @(posedge clk);
        #1;
        m_pc = nxt;
        idle();
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        checks++; if (inst_addr_o !== 32'h0) $display("FAIL reset_pc got %h exp %h", inst_addr_o, 32'h0); else passes++;
        checks++; if (pred_taken_o !== 1'b0) $display("FAIL reset_pred got %b exp 0", pred_taken_o); else passes++;
        checks++; if (pred_target_o !== 32'h0) $display("FAIL reset_tgt got %h exp 0", pred_target_o); else passes++;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (inst_addr_o !== 32'(i * 4) || inst_addr_o !== m_pc) $display("FAIL seq_pc got %h exp %h", inst_addr_o, 32'(i * 4)); else passes++;
            checks++; if (pred_taken_o !== 1'b0) $display("FAIL seq_pred got %b exp 0", pred_taken_o); else passes++;
        end
    endtask

    task automatic test_hold_jump();
        jump = 1; jaddr = 32'h8; step();
        for (int i = 0; i < 3; i++) begin
            hold = 1; step();
            checks++; if (inst_addr_o !== 32'h8) $display("FAIL hold_pc got %h exp %h", inst_addr_o, 32'h8); else passes++;
        end
        hold = 1; jump = 1; jaddr = 32'h100; step();
        checks++; if (inst_addr_o !== 32'h100 || m_pc !== 32'h100) $display("FAIL jump_over_hold got %h exp %h", inst_addr_o, 32'h100); else passes++;
    endtask

    task automatic test_train();
        jump = 1; jaddr = 32'h8; uv = 1; upc = 32'h10; ut = 1; utgt = 32'h40; step();
        checks++; if (inst_addr_o !== 32'h8) $display("FAIL train_pc0 got %h exp %h", inst_addr_o, 32'h8); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'hC) $display("FAIL train_pc1 got %h exp %h", inst_addr_o, 32'hC); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'h10) $display("FAIL train_pc2 got %h exp %h", inst_addr_o, 32'h10); else passes++;
        checks++; if (pred_taken_o !== 1'b1 || pred_taken_o !== mp(m_pc)) $display("FAIL train_pred got %b exp 1", pred_taken_o); else passes++;
        checks++; if (pred_target_o !== 32'h40) $display("FAIL train_tgt got %h exp %h", pred_target_o, 32'h40); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'h40) $display("FAIL train_redirect got %h exp %h", inst_addr_o, 32'h40); else passes++;
        for (int i = 0; i < 2; i++) begin
            hold = 1; uv = 1; upc = 32'h10; ut = 0; step();
        end
        jump = 1; jaddr = 32'h10; step();
        checks++; if (pred_taken_o !== 1'b0 || mp(m_pc) !== 1'b0) $display("FAIL untrain_pred got %b exp 0", pred_taken_o); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'h14) $display("FAIL untrain_pc got %h exp %h", inst_addr_o, 32'h14); else passes++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            hold = 1; uv = 1; upc = 32'h20; ut = 1; utgt = 32'h80; step();
        end
        hold = 1; uv = 1; upc = 32'h20; ut = 0; step();
        jump = 1; jaddr = 32'h20; step();
        checks++; if (pred_taken_o !== 1'b1 || mp(m_pc) !== 1'b1) $display("FAIL sat_pred got %b exp 1", pred_taken_o); else passes++;
        checks++; if (pred_target_o !== 32'h80) $display("FAIL sat_tgt got %h exp %h", pred_target_o, 32'h80); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'h80) $display("FAIL sat_pc got %h exp %h", inst_addr_o, 32'h80); else passes++;
    endtask

    task automatic test_eviction();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            hold = 1; uv = 1; upc = 32'(i * 32'h100); ut = 1; utgt = 32'(i * 32'h100 + 32'h1000); step();
        end
        jump = 1; jaddr = 32'h100; step();
        checks++; if (pred_taken_o !== 1'b0 || mp(32'h100) !== 1'b0) $display("FAIL evict_miss got %b exp 0", pred_taken_o); else passes++;
        for (int i = 2; i <= 5; i++) begin
            jump = 1; jaddr = 32'(i * 32'h100); step();
            checks++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'(i * 32'h100 + 32'h1000) || pred_target_o !== mt(m_pc))
                $display("FAIL evict_hit pc %h got %b/%h exp 1/%h", inst_addr_o, pred_taken_o, pred_target_o, 32'(i * 32'h100 + 32'h1000));
            else passes++;
        end
    endtask

    task automatic test_wrap_reset();
        jump = 1; jaddr = 32'hFFFF_FFFC; uv = 1; upc = 32'h8; ut = 1; utgt = 32'h60; step();
        checks++; if (inst_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_top got %h exp %h", inst_addr_o, 32'hFFFF_FFFC); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'h0) $display("FAIL wrap_pc got %h exp %h", inst_addr_o, 32'h0); else passes++;
        step(); step();
        checks++; if (inst_addr_o !== 32'h8 || pred_taken_o !== 1'b1) $display("FAIL pre_rst_pred got %h/%b exp 8/1", inst_addr_o, pred_taken_o); else passes++;
        step();
        rst_n = 0;
        #1;
        checks++; if (inst_addr_o !== 32'h0) $display("FAIL async_rst_pc got %h exp %h", inst_addr_o, 32'h0); else passes++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        checks++; if (inst_addr_o !== 32'h0) $display("FAIL rst_release_pc got %h exp %h", inst_addr_o, 32'h0); else passes++;
        step(); step();
        checks++; if (inst_addr_o !== 32'h8 || pred_taken_o !== 1'b0) $display("FAIL post_rst_pred got %h/%b exp 8/0", inst_addr_o, pred_taken_o); else passes++;
        step();
        checks++; if (inst_addr_o !== 32'hC) $display("FAIL post_rst_pc got %h exp %h", inst_addr_o, 32'hC); else passes++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            jump  = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            jaddr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            uv    = ($urandom_range(0, 1) == 1);
            upc   = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            ut    = ($urandom_range(0, 2) != 0);
            utgt  = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            if ($urandom_range(0, 3) == 0) upc = m_pc;
            checks++; if (inst_addr_o !== m_pc || pred_taken_o !== mp(m_pc) || pred_target_o !== mt(m_pc))
                $display("FAIL rand cyc %0d got %h/%b/%h exp %h/%b/%h", n, inst_addr_o, pred_taken_o, pred_target_o, m_pc, mp(m_pc), mt(m_pc));
            else passes++;
            step();
        end
        checks++; if (inst_addr_o !== m_pc || pred_taken_o !== mp(m_pc)) $display("FAIL rand_end got %h/%b exp %h/%b", inst_addr_o, pred_taken_o, m_pc, mp(m_pc)); else passes++;
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1;
        test_sequential();
        test_hold_jump();
        test_train();
        test_saturation();
        test_eviction();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
